// File: rtl/image_mem_responder_pkg.sv
// Shared types for the image memory responder: default image sizes, pixel and
// access-address types, and the responder state encoding.
package img_mem_pkg;

    localparam int TEM_DIM_DEF = 32;
    localparam int WIN_DIM_DEF = 64;

    typedef logic [7:0]  pixel_t;
    // {tem_win, row[6:0], col[6:0]} as reported on res_addr
    typedef logic [14:0] addr_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/image_mem_responder_ram.sv
// img_ram: single-port pixel store with one write port and a registered read,
// depth set by DEPTH (one instance per image).
module img_ram
    import img_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/image_mem_responder.sv
// Template/window image store: host loads pixels, then an initiator reads pixels
// and posts result writes. Optional range checking under RESP_OOB_CHECK_EN.
module image_mem_responder
    import img_mem_pkg::*;
#(
    parameter int TEM_DIM = TEM_DIM_DEF,
    parameter int WIN_DIM = WIN_DIM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rd_wr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        set_done,
    input  logic [6:0]  row,
    input  logic [6:0]  col,
    input  logic        tem_win,
    output logic        ready_2_start,
    input  logic        ld_valid,
    input  logic        ld_sel,
    input  logic [6:0]  ld_row,
    input  logic [6:0]  ld_col,
    input  logic [7:0]  ld_pixel,
    input  logic        start,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [14:0] res_addr,
    output logic        done,
    output logic        oob_err
);

    localparam int TAW = $clog2(TEM_DIM);
    localparam int WAW = $clog2(WIN_DIM);

    resp_state_t state, state_next;

    logic             in_load, serving, acc, rd_acc, wr_acc, load_we, oob;
    logic             sel_img;
    logic [6:0]       sel_row, sel_col;
    logic [2*TAW-1:0] t_addr;
    logic [2*WAW-1:0] w_addr;
    pixel_t           t_q, w_q, pix_p1, hold_p1;
    logic             rd_vld_p1, rd_sel_p1, rd_oob_p1;

    assign in_load = (state == ST_LOAD);
    assign serving = (state == ST_READY) || (state == ST_SERVE);

    // The single RAM port belongs to the host during LOAD, to the initiator otherwise.
    assign sel_img = in_load ? ld_sel : tem_win;
    assign sel_row = in_load ? ld_row : row;
    assign sel_col = in_load ? ld_col : col;
    assign t_addr  = {sel_row[TAW-1:0], sel_col[TAW-1:0]};
    assign w_addr  = {sel_row[WAW-1:0], sel_col[WAW-1:0]};

`ifdef RESP_OOB_CHECK_EN
    localparam logic [7:0] TEM_LIM = 8'(TEM_DIM);
    localparam logic [7:0] WIN_LIM = 8'(WIN_DIM);

    assign oob = sel_img ? (({1'b0, sel_row} >= WIN_LIM) || ({1'b0, sel_col} >= WIN_LIM))
                         : (({1'b0, sel_row} >= TEM_LIM) || ({1'b0, sel_col} >= TEM_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else begin
            if (start) begin
                oob_err <= 1'b0;
            end
            if ((acc || (in_load && ld_valid)) && oob) begin
                oob_err <= 1'b1;
            end
        end
    end
`else
    // Coordinates wrap, so only the low address bits reach the RAMs.
    logic unused_bits;
    assign unused_bits = ^{sel_row, sel_col};
    assign oob         = 1'b0;
    assign oob_err     = 1'b0;
`endif

    assign acc     = req && serving;
    assign rd_acc  = acc && rd_wr;
    assign wr_acc  = acc && !rd_wr && !oob;
    assign load_we = in_load && ld_valid && !oob;

    img_ram #(.DEPTH(TEM_DIM * TEM_DIM)) u_tem_ram (
        .clk   (clk),
        .we    (load_we && !ld_sel),
        .addr  (t_addr),
        .wdata (ld_pixel),
        .rdata (t_q)
    );

    img_ram #(.DEPTH(WIN_DIM * WIN_DIM)) u_win_ram (
        .clk   (clk),
        .we    (load_we && ld_sel),
        .addr  (w_addr),
        .wdata (ld_pixel),
        .rdata (w_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        ready_2_start = 1'b0;
        done          = 1'b0;
        case (state)
            ST_LOAD: begin
                if (start) state_next = ST_READY;
            end
            ST_READY: begin
                ready_2_start = 1'b1;
                if (req) state_next = ST_SERVE;
            end
            ST_SERVE: begin
                ready_2_start = 1'b1;
                if (set_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_LOAD;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // p1: RAM output valid; read_data follows it live, then holds the captured pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            hold_p1   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_addr  <= '0;
        end else begin
            rd_vld_p1 <= rd_acc;
            res_valid <= wr_acc;
            if (rd_vld_p1) begin
                hold_p1 <= pix_p1;
            end
            if (wr_acc) begin
                res_data <= write_data;
                res_addr <= addr_t'({tem_win, row, col});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            rd_sel_p1 <= tem_win;
            rd_oob_p1 <= oob;
        end
    end

    assign pix_p1    = rd_oob_p1 ? '0 : (rd_sel_p1 ? w_q : t_q);
    assign read_data = {24'b0, rd_vld_p1 ? pix_p1 : hold_p1};

endmodule

// File: tb/tb_image_mem_responder.sv
// Bench for image_mem_responder: directed scenarios followed by random traffic
// against a behavioural image/state model. Honours RESP_OOB_CHECK_EN.
module tb_image_mem_responder;

    localparam int TEM = 32;
    localparam int WIN = 64;

    logic        clk = 1'b0;
    logic        rst, req, rd_wr, set_done, tem_win, ld_valid, ld_sel, start;
    logic [31:0] write_data;
    logic [6:0]  row, col, ld_row, ld_col;
    logic [7:0]  ld_pixel;
    logic [31:0] read_data, res_data;
    logic [14:0] res_addr;
    logic        ready_2_start, res_valid, done, oob_err;

    image_mem_responder #(.TEM_DIM(TEM), .WIN_DIM(WIN)) dut (
        .clk(clk), .rst(rst), .req(req), .rd_wr(rd_wr), .write_data(write_data),
        .read_data(read_data), .set_done(set_done), .row(row), .col(col),
        .tem_win(tem_win), .ready_2_start(ready_2_start), .ld_valid(ld_valid),
        .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col), .ld_pixel(ld_pixel),
        .start(start), .res_valid(res_valid), .res_data(res_data),
        .res_addr(res_addr), .done(done), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model
    typedef enum {M_LOAD, M_READY, M_SERVE, M_DONE} mstate_t;
    mstate_t     ms = M_LOAD;
    logic [7:0]  tem_m [TEM*TEM];
    logic [7:0]  win_m [WIN*WIN];
    bit          tem_k [TEM*TEM];
    bit          win_k [WIN*WIN];
    logic [31:0] e_rd = 0;
    bit          e_rd_k = 1;
    bit          e_rv = 0;
    logic [31:0] e_rdat = 0;
    logic [14:0] e_radr = 0;
    bit          e_oob = 0;

    function automatic bit is_oob(input logic s, input logic [6:0] r, input logic [6:0] c);
`ifdef RESP_OOB_CHECK_EN
        int d;
        d = s ? WIN : TEM;
        return (int'(r) >= d) || (int'(c) >= d);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pidx(input logic s, input logic [6:0] r, input logic [6:0] c);
        int d;
        d = s ? WIN : TEM;
        return (int'(r) % d) * d + (int'(c) % d);
    endfunction

    task automatic model_step();
        bit act, o;
        int i;
        if (rst) begin
            ms = M_LOAD; e_rd = 0; e_rd_k = 1; e_rv = 0; e_rdat = 0; e_radr = 0; e_oob = 0;
            for (int k = 0; k < TEM*TEM; k++) tem_k[k] = 0;
            for (int k = 0; k < WIN*WIN; k++) win_k[k] = 0;
            return;
        end
        e_rv = 0;
        act = req && (ms == M_READY || ms == M_SERVE);
        if (ms == M_LOAD && ld_valid && !is_oob(ld_sel, ld_row, ld_col)) begin
            i = pidx(ld_sel, ld_row, ld_col);
            if (ld_sel) begin win_m[i] = ld_pixel; win_k[i] = 1; end
            else        begin tem_m[i] = ld_pixel; tem_k[i] = 1; end
        end
        o = is_oob(tem_win, row, col);
        if (act && rd_wr) begin
            if (o) begin
                e_rd = 0; e_rd_k = 1;
            end else begin
                i = pidx(tem_win, row, col);
                e_rd   = tem_win ? {24'b0, win_m[i]} : {24'b0, tem_m[i]};
                e_rd_k = tem_win ? win_k[i] : tem_k[i];
            end
        end else if (act && !o) begin
            e_rv = 1; e_rdat = write_data; e_radr = {tem_win, row, col};
        end
        if (start) e_oob = 0;
        if ((act && o) || (ms == M_LOAD && ld_valid && is_oob(ld_sel, ld_row, ld_col))) e_oob = 1;
        case (ms)
            M_LOAD:  if (start)    ms = M_READY;
            M_READY: if (req)      ms = M_SERVE;
            M_SERVE: if (set_done) ms = M_DONE;
            M_DONE:  if (start)    ms = M_LOAD;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        if (e_rd_k) chk("read_data", read_data, e_rd);
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        chk("res_data", res_data, e_rdat);
        chk("res_addr", 32'(res_addr), 32'(e_radr));
        chk("ready_2_start", 32'(ready_2_start), 32'(ms == M_READY || ms == M_SERVE));
        chk("done", 32'(done), 32'(ms == M_DONE));
        chk("oob_err", 32'(oob_err), 32'(e_oob));
    endtask

    task automatic idle();
        rst = 0; req = 0; rd_wr = 0; set_done = 0; ld_valid = 0; start = 0;
    endtask

    function automatic logic [6:0] rand_coord(input logic s);
        if ($urandom_range(0, 7) == 0) return 7'($urandom_range(0, 127));
        return 7'($urandom_range(0, s ? WIN - 1 : TEM - 1));
    endfunction

    initial begin
        idle();
        rst = 1; tem_win = 0; row = 0; col = 0; write_data = 0;
        ld_sel = 0; ld_row = 0; ld_col = 0; ld_pixel = 0;
        cycle();
        cycle();
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_ready", 32'(ready_2_start), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 0;

        // Load template r*c%256 and a random window
        for (int r = 0; r < TEM; r++) begin
            for (int c = 0; c < TEM; c++) begin
                ld_valid = 1; ld_sel = 0; ld_row = 7'(r); ld_col = 7'(c); ld_pixel = 8'(r * c);
                cycle();
            end
        end
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                ld_valid = 1; ld_sel = 1; ld_row = 7'(r); ld_col = 7'(c);
                ld_pixel = 8'($urandom_range(0, 255));
                cycle();
            end
        end
        ld_valid = 0; start = 1;
        cycle();
        start = 0;
        chk("start_ready", 32'(ready_2_start), 32'd1);

        req = 1; rd_wr = 1; tem_win = 0; row = 7'd5; col = 7'd7;
        cycle();
        chk("read_5_7", read_data, 32'd35);
        chk("serve_ready", 32'(ready_2_start), 32'd1);
        row = 7'd3; col = 7'd3;
        cycle();
        chk("read_3_3", read_data, 32'd9);
        row = 7'd4; col = 7'd4;
        cycle();
        chk("read_4_4", read_data, 32'd16);

        rd_wr = 0; write_data = 32'hDEADBEEF; tem_win = 1; row = 7'd2; col = 7'd1;
        cycle();
        chk("wr_valid", 32'(res_valid), 32'd1);
        chk("wr_data", res_data, 32'hDEADBEEF);
        chk("wr_addr", 32'(res_addr), 32'h4101);
        req = 0;
        cycle();
        chk("wr_pulse_end", 32'(res_valid), 32'd0);
        chk("read_hold", read_data, 32'd16);

        set_done = 1;
        cycle();
        set_done = 0;
        chk("done_set", 32'(done), 32'd1);
        chk("done_ready", 32'(ready_2_start), 32'd0);
        req = 1; rd_wr = 1; tem_win = 0; row = 7'd5; col = 7'd7;
        cycle();
        chk("done_read_ignored", read_data, 32'd16);
        rd_wr = 0;
        cycle();
        chk("done_write_ignored", 32'(res_valid), 32'd0);
        req = 0; start = 1;
        cycle();
        start = 0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_ready", 32'(ready_2_start), 32'd0);

`ifdef RESP_OOB_CHECK_EN
        start = 1;
        cycle();
        start = 0;
        req = 1; rd_wr = 1; tem_win = 0; row = 7'd40; col = 7'd0;
        cycle();
        req = 0;
        chk("oob_read", read_data, 32'd0);
        chk("oob_flag", 32'(oob_err), 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        chk("oob_rst_read", read_data, 32'd0);
        chk("oob_rst_flag", 32'(oob_err), 32'd0);
        chk("oob_rst_ready", 32'(ready_2_start), 32'd0);
        chk("oob_rst_valid", 32'(res_valid), 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 8000; n++) begin
            rst        = ($urandom_range(0, 699) == 0);
            req        = ($urandom_range(0, 1) == 1);
            rd_wr      = ($urandom_range(0, 2) != 0);
            set_done   = ($urandom_range(0, 39) == 0);
            start      = ($urandom_range(0, 59) == 0);
            ld_valid   = ($urandom_range(0, 3) != 0);
            ld_sel     = 1'($urandom_range(0, 1));
            ld_row     = rand_coord(ld_sel);
            ld_col     = rand_coord(ld_sel);
            ld_pixel   = 8'($urandom_range(0, 255));
            tem_win    = 1'($urandom_range(0, 1));
            row        = rand_coord(tem_win);
            col        = rand_coord(tem_win);
            write_data = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/image_mem_responder.md
IMAGE_MEM_RESPONDER -- requirements
Module: image_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TEM_DIM  32  template image side length, pixels
  WIN_DIM  64  window image side length, pixels (max 128)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  req  in  1  initiator access request, one access per cycle
  rd_wr  in  1  1 = read, 0 = write
  write_data  in  32  initiator write payload
  read_data  out  32  pixel returned to initiator, zero-extended 8-bit
  set_done  in  1  initiator signals job complete
  row  in  7  access row
  col  in  7  access col
  tem_win  in  1  0 = template image, 1 = window image
  ready_2_start  out  1  images loaded, initiator may begin
  ld_valid  in  1  host pixel load strobe
  ld_sel  in  1  0 = template, 1 = window
  ld_row  in  7  host load row
  ld_col  in  7  host load col
  ld_pixel  in  8  host load pixel
  start  in  1  host: loading finished, arm initiator
  res_valid  out  1  one-cycle pulse: initiator write captured
  res_data  out  32  captured write_data
  res_addr  out  15  captured {tem_win,row,col}
  done  out  1  job complete, held until next start
  oob_err  out  1  sticky out-of-range access flag

Function
REQ-003 FSM states SHALL be LOAD, READY, SERVE, DONE; after reset the state SHALL be LOAD.
REQ-004 LOAD: ld_valid writes ld_pixel at (ld_row,ld_col) of selected image in the same cycle; ld_valid outside LOAD SHALL be ignored.
REQ-005 LOAD -> READY on start; READY -> SERVE on first req; SERVE -> DONE on set_done; DONE -> LOAD on start.
REQ-006 ready_2_start SHALL be 1 in READY and SERVE, 0 in LOAD and DONE.
REQ-007 Read (req & rd_wr in READY/SERVE): read_data SHALL present {24'b0,pixel} exactly 1 cycle after req and hold until the next read completes.
REQ-008 Back-to-back reads SHALL be accepted every cycle with 1-cycle latency and no stall.
REQ-009 Write (req & ~rd_wr in READY/SERVE): res_valid SHALL pulse the next cycle with res_data = write_data, res_addr = {tem_win,row,col}; image memory unchanged.
REQ-010 req in LOAD or DONE SHALL be ignored: read_data holds, no res_valid.
REQ-011 req and set_done in the same SERVE cycle: access SHALL complete normally, then DONE.
REQ-012 done SHALL be 1 only in DONE.
REQ-013 Image storage SHALL be 8 bits/pixel, TEM_DIM^2 template plus WIN_DIM^2 window entries.

Reset
REQ-014 rst SHALL force state LOAD, read_data 0, ready_2_start 0, res_valid 0, res_data 0, res_addr 0, done 0, oob_err 0.
REQ-015 rst mid-SERVE SHALL abort the job, drop any pending res_valid; image contents SHALL be undefined after reset.

Configuration
REQ-016 With RESP_OOB_CHECK_EN defined, row/col >= selected image dim SHALL return read_data 0, suppress writes/loads, and set oob_err until rst or start.
REQ-017 Without RESP_OOB_CHECK_EN, row/col SHALL wrap modulo the image dim (dims power of two) and oob_err SHALL be tied 0.

Structure
REQ-018 Package img_mem_pkg SHALL hold TEM_DIM/WIN_DIM defaults, pixel_t (8-bit), addr_t, and the state enum resp_state_t.
REQ-019 Sub-module img_ram (single-port, synchronous-read, parameterized depth) SHALL be instantiated once per image.

Verification
REQ-020 Load template pixel (r,c) = r*c%256, start -> ready_2_start 1 the next cycle.
REQ-021 READY, req rd_wr=1 tem_win=0 row=5 col=7 -> read_data 35 one cycle later, state SERVE.
REQ-022 Back-to-back reads (3,3),(4,4) -> read_data 9 then 16 on consecutive cycles.
REQ-023 Write write_data=0xDEADBEEF tem_win=1 row=2 col=1 -> res_valid pulse, res_data 0xDEADBEEF, res_addr 0x4101.
REQ-024 set_done in SERVE -> done 1, ready_2_start 0; later req ignored; start -> LOAD, done 0.
REQ-025 RESP_OOB_CHECK_EN: template read row=40 -> read_data 0, oob_err 1; rst mid-SERVE -> all outputs 0, state LOAD.
